// File: rtl/rob_pkg.sv
// Shared sizes and the entry record for the reorder buffer.
package rob_pkg;
    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = 5;
    localparam int REG_W     = 5;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 6;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              wr;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;
endpackage

// File: rtl/rob_if.sv
// Dispatch, CDB, operand lookup, rename-table and commit signals of the ROB.
interface rob_if;
    import rob_pkg::*;

    logic              disp_valid;
    logic              disp_wr;
    logic [REG_W-1:0]  disp_rd;
    logic              disp_ready;
    logic [TAG_W-1:0]  disp_tag;
    logic              Wen_rst;
    logic [REG_W-1:0]  Waddr_rst;
    logic [TAG_W-1:0]  Wdata_rst;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  rd_tag_a;
    logic [TAG_W-1:0]  rd_tag_b;
    logic              rd_ready_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_ready_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              RB_valid_rst;
    logic [TAG_W-1:0]  RB_tag_rst;
    logic              rf_wen;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  count;

    modport master (
        output disp_valid, disp_wr, disp_rd, cdb_valid, cdb_tag, cdb_data,
               rd_tag_a, rd_tag_b,
        input  disp_ready, disp_tag, Wen_rst, Waddr_rst, Wdata_rst,
               rd_ready_a, rd_data_a, rd_ready_b, rd_data_b,
               RB_valid_rst, RB_tag_rst, rf_wen, rf_waddr, rf_wdata, count
    );

    modport slave (
        input  disp_valid, disp_wr, disp_rd, cdb_valid, cdb_tag, cdb_data,
               rd_tag_a, rd_tag_b,
        output disp_ready, disp_tag, Wen_rst, Waddr_rst, Wdata_rst,
               rd_ready_a, rd_data_a, rd_ready_b, rd_data_b,
               RB_valid_rst, RB_tag_rst, rf_wen, rf_waddr, rf_wdata, count
    );
endinterface

// File: rtl/rob_ptr.sv
// Wrap-around buffer pointer; the natural 5-bit overflow gives the 31 -> 0 wrap.
module rob_ptr
    import rob_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [TAG_W-1:0] ptr
);
    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/rob.sv
// 32-entry reorder buffer: in-order dispatch, CDB result capture with lookup
// bypass, and in-order single-entry commit to the architectural register file.
module rob
    import rob_pkg::*;
(
    input  logic clock,
    input  logic reset,
    rob_if.slave bus
);
    logic [ROB_DEPTH-1:0] busy_q;
    logic [ROB_DEPTH-1:0] ready_q;
    logic [ROB_DEPTH-1:0] wr_q;
    logic [REG_W-1:0]     rd_q   [ROB_DEPTH];
    logic [DATA_W-1:0]    data_q [ROB_DEPTH];
    rob_entry_t           ent    [ROB_DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             disp_acc;
    logic             commit;
    logic             commit_wr;
    rob_entry_t       head_e;
    logic [DATA_W:0]  look_a;
    logic [DATA_W:0]  look_b;

    function automatic logic [DATA_W:0] lookup(input rob_entry_t e, input logic hit,
                                               input logic [DATA_W-1:0] cdb_d);
        if (e.busy && hit)
            return {1'b1, cdb_d};
        else if (e.busy)
            return {e.ready, e.data};
        else
            return '0;
    endfunction

    for (genvar g = 0; g < ROB_DEPTH; g++) begin : g_ent
        assign ent[g] = '{busy: busy_q[g], ready: ready_q[g], wr: wr_q[g],
                          rd: rd_q[g], data: data_q[g]};
    end

    assign full      = (cnt == CNT_W'(ROB_DEPTH));
    assign disp_acc  = !reset && bus.disp_valid && !full;
    assign head_e    = ent[head];
    assign commit    = !reset && head_e.busy && head_e.ready;
    assign commit_wr = commit && head_e.wr && (head_e.rd != '0);

    rob_ptr u_head (.clock(clock), .reset(reset), .inc(commit),   .ptr(head));
    rob_ptr u_tail (.clock(clock), .reset(reset), .inc(disp_acc), .ptr(tail));

    // Reset masks the outputs combinationally so the reset cycle itself is quiet.
    assign bus.disp_ready   = reset || !full;
    assign bus.disp_tag     = reset ? '0 : tail;
    assign bus.Wen_rst      = disp_acc && bus.disp_wr && (bus.disp_rd != '0);
    assign bus.Waddr_rst    = bus.disp_rd;
    assign bus.Wdata_rst    = reset ? '0 : tail;
    assign bus.RB_valid_rst = commit_wr;
    assign bus.RB_tag_rst   = reset ? '0 : head;
    assign bus.rf_wen       = commit_wr;
    assign bus.rf_waddr     = head_e.rd;
    assign bus.rf_wdata     = head_e.data;
    assign bus.count        = reset ? '0 : cnt;

    assign look_a = lookup(ent[bus.rd_tag_a], bus.cdb_valid && (bus.cdb_tag == bus.rd_tag_a),
                           bus.cdb_data);
    assign look_b = lookup(ent[bus.rd_tag_b], bus.cdb_valid && (bus.cdb_tag == bus.rd_tag_b),
                           bus.cdb_data);
    assign {bus.rd_ready_a, bus.rd_data_a} = look_a;
    assign {bus.rd_ready_b, bus.rd_data_b} = look_b;

    // Dispatch is ordered last so a fresh allocation always starts not-ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            if (bus.cdb_valid && busy_q[bus.cdb_tag])
                ready_q[bus.cdb_tag] <= 1'b1;
            if (commit)
                busy_q[head] <= 1'b0;
            if (disp_acc) begin
                busy_q[tail]  <= 1'b1;
                ready_q[tail] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && bus.cdb_valid && busy_q[bus.cdb_tag])
            data_q[bus.cdb_tag] <= bus.cdb_data;
        if (disp_acc) begin
            wr_q[tail] <= bus.disp_wr;
            rd_q[tail] <= bus.disp_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else begin
            case ({disp_acc, commit})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_rob.sv
// Directed bench for the ROB; rename writes and commits are checked by a queue-based monitor.
module tb_rob;
    import rob_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rob_if b ();
    rob dut (.clock(clock), .reset(reset), .bus(b.slave));

    int errors = 0;
    int checks = 0;

    logic [9:0]  wen_q [$];   // {rd, tag}
    logic [41:0] com_q [$];   // {rd, data, tag}
    logic [9:0]  w_exp;
    logic [41:0] c_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        b.disp_valid = 1'b0; b.disp_wr = 1'b0; b.disp_rd = '0;
        b.cdb_valid = 1'b0; b.cdb_tag = '0; b.cdb_data = '0;
        b.rd_tag_a = '0; b.rd_tag_b = '0;
    endtask

    task automatic step();
        @(posedge clock); #1;
        idle();
    endtask

    task automatic disp(input logic wr, input logic [4:0] rd);
        b.disp_valid = 1'b1; b.disp_wr = wr; b.disp_rd = rd;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
        b.cdb_valid = 1'b1; b.cdb_tag = tag; b.cdb_data = data;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_disp_ready", b.disp_ready, 1);
        chk("rst_disp_tag",   b.disp_tag, 0);
        chk("rst_count",      b.count, 0);
        chk("rst_wen",        b.Wen_rst, 0);
        chk("rst_rf_wen",     b.rf_wen, 0);
        chk("rst_rb_tag",     b.RB_tag_rst, 0);
        step();
        reset = 1'b0;
    endtask

    // Monitor: every rename write and every register-writing commit must match the next expectation.
    always @(negedge clock) begin
        if (b.Wen_rst) begin
            if (wen_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wen_unexpected: got Waddr_rst=%0d Wdata_rst=%0d, required no write",
                         b.Waddr_rst, b.Wdata_rst);
            end else begin
                w_exp = wen_q.pop_front();
                chk("wen_waddr", b.Waddr_rst, w_exp[9:5]);
                chk("wen_wdata", b.Wdata_rst, w_exp[4:0]);
            end
        end
        if (b.rf_wen || b.RB_valid_rst) begin
            if (com_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL commit_unexpected: got rf_waddr=%0d tag=%0d, required no commit",
                         b.rf_waddr, b.RB_tag_rst);
            end else begin
                c_exp = com_q.pop_front();
                chk("commit_waddr",  b.rf_waddr, c_exp[41:37]);
                chk("commit_wdata",  b.rf_wdata, c_exp[36:5]);
                chk("commit_tag",    b.RB_tag_rst, c_exp[4:0]);
                chk("commit_rbv_eq", b.RB_valid_rst, b.rf_wen);
            end
        end
    end

    initial begin
        idle();
        apply_reset();

        // First dispatch after reset
        disp(1, 3); wen_q.push_back({5'd3, 5'd0});
        @(negedge clock);
        chk("a_tag", b.disp_tag, 0);
        chk("a_wen", b.Wen_rst, 1);
        step();
        @(negedge clock);
        chk("a_count", b.count, 1);

        // Out-of-order completion, in-order commit, bypass lookup
        apply_reset();
        disp(1, 4); wen_q.push_back({5'd4, 5'd0}); step();
        disp(1, 5); wen_q.push_back({5'd5, 5'd1}); step();
        cdb(1, 32'hAA); b.rd_tag_a = 1; b.rd_tag_b = 0;
        @(negedge clock);
        chk("b_byp_rdy_a",  b.rd_ready_a, 1);
        chk("b_byp_data_a", b.rd_data_a, 32'hAA);
        chk("b_rdy_b",      b.rd_ready_b, 0);
        step();
        cdb(0, 32'h55); b.rd_tag_a = 1;
        com_q.push_back({5'd4, 32'h55, 5'd0});
        com_q.push_back({5'd5, 32'hAA, 5'd1});
        @(negedge clock);
        chk("b_reg_rdy_a",  b.rd_ready_a, 1);
        chk("b_reg_data_a", b.rd_data_a, 32'hAA);
        chk("b_no_commit",  b.rf_wen, 0);
        step();
        disp(1, 6); wen_q.push_back({5'd6, 5'd2});
        @(negedge clock);
        chk("b_commit0", b.rf_wen, 1);
        chk("b_tag2",    b.disp_tag, 2);
        step();
        @(negedge clock);
        chk("b_count_same", b.count, 2);
        chk("b_commit1",    b.RB_tag_rst, 1);
        step();
        @(negedge clock);
        chk("b_count_dec", b.count, 1);

        // Same-cycle CDB bypass on a busy, not-ready entry
        apply_reset();
        disp(1, 1); wen_q.push_back({5'd1, 5'd0}); step();
        disp(1, 2); wen_q.push_back({5'd2, 5'd1}); step();
        disp(1, 3); wen_q.push_back({5'd3, 5'd2}); step();
        cdb(2, 32'h1234); b.rd_tag_a = 2; b.rd_tag_b = 3;
        @(negedge clock);
        chk("c_byp_rdy_a",  b.rd_ready_a, 1);
        chk("c_byp_data_a", b.rd_data_a, 32'h1234);
        chk("c_free_rdy_b", b.rd_ready_b, 0);
        step();

        // Reset dominates a pending commit
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            disp(1, 5'(i + 1)); wen_q.push_back({5'(i + 1), 5'(i)}); step();
        end
        cdb(0, 32'h1);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("d_rst_count",  b.count, 0);
        chk("d_rst_rf_wen", b.rf_wen, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("d_count",   b.count, 0);
        chk("d_rf_wen",  b.rf_wen, 0);
        chk("d_tag",     b.disp_tag, 0);
        chk("d_ready",   b.disp_ready, 1);
        step();
        @(negedge clock);
        chk("d_no_commit_late", b.rf_wen, 0);

        // Commits that do not write the register file still retire
        apply_reset();
        disp(1, 0);
        @(negedge clock);
        chk("e_wen_rd0", b.Wen_rst, 0);
        step();
        disp(0, 7);
        @(negedge clock);
        chk("e_wen_nowr", b.Wen_rst, 0);
        chk("e_tag1",     b.disp_tag, 1);
        step();
        cdb(0, 32'h9); step();
        cdb(1, 32'h8);
        @(negedge clock);
        chk("e_rbv0",   b.RB_valid_rst, 0);
        chk("e_rfw0",   b.rf_wen, 0);
        chk("e_rbtag0", b.RB_tag_rst, 0);
        step();
        @(negedge clock);
        chk("e_count1", b.count, 1);
        chk("e_rbtag1", b.RB_tag_rst, 1);
        chk("e_rfw1",   b.rf_wen, 0);
        step();
        @(negedge clock);
        chk("e_count0", b.count, 0);
        chk("e_tail",   b.disp_tag, 2);

        // Fill to 32, refused dispatch, commit while full, wrap to tag 0
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            disp(1, 5'((i % 31) + 1)); wen_q.push_back({5'((i % 31) + 1), 5'(i)});
            @(negedge clock);
            chk("f_tag", b.disp_tag, i);
            step();
        end
        disp(1, 9);
        @(negedge clock);
        chk("f_full_count", b.count, 32);
        chk("f_full_ready", b.disp_ready, 0);
        chk("f_wen_refused", b.Wen_rst, 0);
        step();
        disp(1, 9); cdb(0, 32'hC0);
        com_q.push_back({5'd1, 32'hC0, 5'd0});
        @(negedge clock);
        chk("f_count_hold", b.count, 32);
        step();
        @(negedge clock);
        chk("f_commit_full", b.rf_wen, 1);
        chk("f_ready_commit", b.disp_ready, 0);
        step();
        disp(1, 10); wen_q.push_back({5'd10, 5'd0});
        @(negedge clock);
        chk("f_count31",  b.count, 31);
        chk("f_ready_again", b.disp_ready, 1);
        chk("f_wrap_tag", b.disp_tag, 0);
        step();
        @(negedge clock);
        chk("f_refull",   b.count, 32);
        chk("f_refull_rdy", b.disp_ready, 0);
        step();

        chk("wen_q_drained", wen_q.size(), 0);
        chk("com_q_drained", com_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-003 disp_valid  in  1  dispatch request for one instruction this cycle.
REQ-004 disp_wr  in  1  dispatched instruction writes a destination register.
REQ-005 disp_rd  in  5  destination register address.
REQ-006 disp_ready  out  1  ROB not full; dispatch accepted when disp_valid && disp_ready.
REQ-007 disp_tag  out  5  tag (tail index) assigned to the current dispatch.
REQ-008 Wen_rst / Waddr_rst / Wdata_rst  out  1/5/5  RST rename write: enable, register address, tag.
REQ-009 cdb_valid / cdb_tag / cdb_data  in  1/5/32  result broadcast: valid, producing tag, value.
REQ-010 rd_tag_a, rd_tag_b  in  5 each  operand lookup tags (Rs, Rt).
REQ-011 rd_ready_a/rd_data_a, rd_ready_b/rd_data_b  out  1/32 each  lookup result ready flag and value.
REQ-012 RB_valid_rst / RB_tag_rst  out  1/5  commit notice to RST: clear the entry whose tag matches.
REQ-013 rf_wen / rf_waddr / rf_wdata  out  1/5/32  architectural register file write at commit.
REQ-014 count  out  6  number of allocated entries, 0..32.

Function
REQ-015 ROB SHALL be a 32-entry circular buffer; each entry holds busy, ready, wr, rd[4:0], data[31:0].
REQ-016 disp_tag SHALL equal the tail pointer combinationally; disp_ready SHALL be (count != 32), independent of same-cycle commit.
REQ-017 On accepted dispatch the entry at tail SHALL become busy=1, ready=0, wr=disp_wr, rd=disp_rd at the edge; tail SHALL increment mod 32 (31 -> 0).
REQ-018 Wen_rst SHALL be asserted combinationally in the dispatch cycle iff dispatch accepted && disp_wr && disp_rd != 0, with Waddr_rst=disp_rd, Wdata_rst=disp_tag.
REQ-019 Dispatch with disp_ready=0 SHALL be ignored: no state change, Wen_rst=0.
REQ-020 cdb_valid to a busy entry SHALL set ready=1 and data=cdb_data at the edge; to a non-busy entry SHALL be ignored.
REQ-021 Lookup SHALL be combinational: rd_ready_x=1, rd_data_x=cdb_data if cdb_valid && cdb_tag==rd_tag_x && entry busy (bypass); else entry ready and data; rd_ready_x=0 for non-busy entries.
REQ-022 Commit SHALL occur in the cycle head entry is busy && ready (ready as registered; a CDB write to head commits one cycle later); at most one commit per cycle, strictly in order.
REQ-023 In a commit cycle, combinationally: RB_tag_rst=head, RB_valid_rst=rf_wen=(wr && rd!=0), rf_waddr=rd, rf_wdata=data; at the edge entry busy=0 and head increments mod 32.
REQ-024 No commit while empty or head not ready; RB_valid_rst=rf_wen=0 then.
REQ-025 Simultaneous dispatch and commit SHALL leave count unchanged; dispatch-only +1, commit-only -1.
REQ-026 When full (count=32) a commit SHALL still occur; dispatch accepted again next cycle.

Reset
REQ-027 reset SHALL clear head, tail, count to 0 and every busy/ready bit to 0; data/rd need not be cleared.
REQ-028 reset SHALL dominate dispatch, CDB and commit in the same cycle; mid-operation all in-flight entries are discarded.
REQ-029 While reset=1 and after it: disp_ready=1, disp_tag=0, all enables and valids 0, count=0, RB_tag_rst=0.

Structure
REQ-030 Package rob_pkg SHALL hold ROB_DEPTH=32, TAG_W=5, REG_W=5, DATA_W=32 and the entry record type.
REQ-031 One sub-module rob_ptr (5-bit wrap-around pointer with increment enable and sync reset) SHALL be instantiated for head and tail.

Verification
REQ-032 After reset, dispatch rd=3,wr=1 -> disp_tag=0, Wen_rst=1, Waddr_rst=3, Wdata_rst=0; count=1 next cycle.
REQ-033 Tags 0,1 dispatched (rd=4,5); CDB tag 1 data 0xAA then tag 0 data 0x55 -> commit tag 0 (rf_waddr=4, 0x55) then tag 1 (rf_waddr=5, 0xAA); RB_tag_rst 0 then 1.
REQ-034 32 dispatches -> count=32, disp_ready=0; 33rd ignored (Wen_rst=0); one commit -> next dispatch gets tag 0 (wrap).
REQ-035 cdb_valid tag 2 data 0x1234 with rd_tag_a=2 busy, not ready -> same-cycle rd_ready_a=1, rd_data_a=0x1234.
REQ-036 Dispatch rd=0 -> Wen_rst=0; at commit RB_valid_rst=0, rf_wen=0, head advances.
REQ-037 reset asserted with 5 entries busy, commit pending -> next cycle count=0, no commit, disp_tag=0.
